fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC, issues one instruction-memory request
// at a time, and holds each returned instruction until decode accepts it.
// Branch redirects from execute override everything else and squash any
// response still in flight for the old path.
//
// Handshakes:
//   imem_req/imem_gnt : a request transfers in a cycle where both are high;
//                       while imem_req is high without imem_gnt, imem_addr is
//                       held stable. Only one request is ever outstanding.
//   imem_rvalid       : one-shot response strobe, 1 or more cycles after the
//                       accepted request; imem_rdata is sampled in that cycle.
//   if_valid/id_ready : an instruction transfers to decode in a cycle where
//                       both are high; while if_valid is high without
//                       id_ready, if_instr and if_pc are held stable.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready,
   output logic [31:0] pc_out,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] br_aligned;

   // Low two target bits are dropped so the PC always stays word-aligned.
   assign br_aligned = {br_target[31:2], 2'b00};

   // Next-state and next-register computation; branch redirect wins in every state.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      squash_d = squash_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      if (br_taken) begin
         pc_d    = br_aligned;
         valid_d = 1'b0;
      end
      case (state_q)
         FETCH: begin
            if (imem_gnt) begin
               state_d = WAIT;
               // A request accepted alongside a redirect targets the old path.
               if (br_taken) begin
                  squash_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (br_taken) begin
               if (imem_rvalid) begin
                  // Response lands on the redirect cycle: drop it, nothing left in flight.
                  squash_d = 1'b0;
                  state_d  = FETCH;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = FETCH;
               end else begin
                  instr_d = imem_rdata;
                  ipc_d   = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (br_taken) begin
               state_d = FETCH;
            end else if (id_ready) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         squash_q <= 1'b0;
         valid_q  <= 1'b0;
         instr_q  <= 32'd0;
         ipc_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         squash_q <= squash_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
      end
   end

   // Request is suppressed during reset so an abandoned transaction cannot restart early.
   assign imem_req  = (state_q == FETCH) && !rst;
   assign imem_addr = pc_q;
   assign if_valid  = valid_q;
   assign if_instr  = instr_q;
   assign if_pc     = ipc_q;
   assign pc_out    = pc_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model answers requests with random
// grant and latency, a reference model tracks the architectural PC and which
// responses must reach decode, and a monitor checks each presented instruction.
module tb_fetch_unit;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        br_taken;
   logic [31:0] br_target;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic [31:0] pc_out;
   logic [1:0]  dbg_state;

   fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .id_ready    (id_ready),
      .pc_out      (pc_out),
      .dbg_state   (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: {pc, instr} of each instruction decode must see, in order
   logic [63:0] exp_q[$];
   int n_cmp  = 0;
   int n_bad  = 0;
   int n_deliv = 0;

   // Reference model state
   logic [31:0] model_pc;
   logic        outstanding;
   logic        useful;
   logic [31:0] req_addr;
   int          lat_cnt;

   // Stimulus knobs
   int          gnt_pct = 100;
   int          br_pct  = 0;
   int          rdy_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   logic        use_fixed = 1'b0;
   logic [31:0] fixed_data = 32'd0;
   logic        force_br = 1'b0;
   logic        force_wait = 1'b0;
   logic [31:0] force_tgt = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: check outputs at the negedge, drive inputs, advance the model.
   task automatic cycle();
      logic accepted;
      @(negedge clk);
      check("pc_out", pc_out, model_pc);
      if (imem_req) check("imem_addr", imem_addr, model_pc);
      if (if_valid) check("no_req_while_valid", {31'd0, imem_req}, 32'd0);

      imem_rvalid = 1'b0;
      imem_rdata  = use_fixed ? fixed_data : $urandom;
      if (outstanding) begin
         lat_cnt--;
         if (lat_cnt == 0) imem_rvalid = 1'b1;
      end
      imem_gnt  = ($urandom_range(99) < gnt_pct);
      br_taken  = ($urandom_range(99) < br_pct);
      br_target = $urandom_range(1) ? $urandom : $urandom_range(255);
      if (force_br && (!force_wait || (outstanding && !imem_rvalid))) begin
         br_taken  = 1'b1;
         br_target = force_tgt;
         force_br  = 1'b0;
      end
      id_ready = ($urandom_range(99) < rdy_pct);

      accepted = imem_req && imem_gnt && !outstanding;
      if (accepted) begin
         outstanding = 1'b1;
         req_addr    = model_pc;
         useful      = 1'b1;
         lat_cnt     = $urandom_range(lat_max, lat_min);
      end else if (imem_rvalid) begin
         outstanding = 1'b0;
         if (useful && !br_taken) begin
            exp_q.push_back({req_addr, imem_rdata});
            model_pc = req_addr + 32'd4;
            n_deliv++;
         end
      end
      if (br_taken) begin
         useful   = 1'b0;
         model_pc = {br_target[31:2], 2'b00};
      end
   endtask

   // Reset for one cycle, optionally followed by a stale response in the first FETCH cycle.
   task automatic do_reset(input logic stale_rvalid);
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; br_taken = 1'b0; id_ready = 1'b0;
      imem_rdata = $urandom; br_target = 32'd0;
      @(negedge clk);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_pc_out", pc_out, TB_RESET_PC);
      rst = 1'b0;
      model_pc = TB_RESET_PC; outstanding = 1'b0; useful = 1'b0; lat_cnt = 0;
      exp_q.delete();
      @(negedge clk);
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, TB_RESET_PC);
      check("first_if_valid", {31'd0, if_valid}, 32'd0);
      imem_rvalid = stale_rvalid;
      imem_gnt = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Monitor: compares each newly presented instruction and its stability while held.
   logic        prev_v = 1'b0;
   logic [63:0] held;
   always @(posedge clk) begin
      #1;
      if (if_valid && !prev_v) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_if_valid: got pc %h instr %h expected nothing at %0t", if_pc, if_instr, $time);
         end else begin
            held = exp_q.pop_front();
            check("if_pc", if_pc, held[63:32]);
            check("if_instr", if_instr, held[31:0]);
         end
      end else if (if_valid && prev_v) begin
         check("hold_if_pc", if_pc, held[63:32]);
         check("hold_if_instr", if_instr, held[31:0]);
      end
      prev_v = if_valid;
   end

   initial begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      br_taken = 1'b0; br_target = 32'd0; id_ready = 1'b0;
      model_pc = TB_RESET_PC; outstanding = 1'b0; useful = 1'b0; req_addr = 32'd0; lat_cnt = 0;
      @(negedge clk);
      do_reset(1'b0);

      // First fetch: immediate grant, 1-cycle response, decode ready
      use_fixed = 1'b1; fixed_data = 32'hE3A0_0001;
      run(6);
      use_fixed = 1'b0;

      // Grant withheld for three cycles: request and address must hold
      gnt_pct = 0; run(3);
      gnt_pct = 100; run(4);

      // Decode stalls: instruction held, no new request
      rdy_pct = 0; lat_min = 2; lat_max = 2; run(10);
      rdy_pct = 100; run(3);

      // Redirect while waiting: stale data dropped, next fetch at 0x100
      lat_min = 3; lat_max = 3;
      force_tgt = 32'h0000_0103; force_wait = 1'b1; force_br = 1'b1;
      run(12);

      // PC wrap at the top of the address space
      lat_min = 1; lat_max = 2; force_wait = 1'b0;
      force_tgt = 32'hFFFF_FFFC; force_br = 1'b1;
      run(12);

      // Reset while a request is outstanding, then a stale response
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 50 && !outstanding; i++) cycle();
      @(negedge clk);
      do_reset(1'b1);
      lat_min = 1; lat_max = 2;
      run(8);

      // Random traffic
      for (int blk = 0; blk < 30; blk++) begin
         gnt_pct = $urandom_range(90, 30);
         br_pct  = $urandom_range(15, 0);
         rdy_pct = $urandom_range(90, 30);
         lat_min = 1;
         lat_max = $urandom_range(4, 1);
         run(60);
      end

      // Drain: no redirects, decode always ready
      br_pct = 0; rdy_pct = 100; gnt_pct = 100; lat_max = 2;
      run(20);
      check("drain_exp_q_empty", exp_q.size(), 32'd0);
      n_cmp++;
      if (n_deliv < 20) begin
         n_bad++;
         $display("FAIL deliveries: got %0d expected at least 20", n_deliv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
